// File: rtl/xcr_intc_if.sv
// XCR bus between the KC_LS1u_plus core (master) and an XCR responder (slave).
interface xcr_intc_if;
   logic [7:0] xcr_a;
   logic [7:0] xcr_wdata;
   logic       xcr_we;
   logic       xcr_cs;
   logic [7:0] xcr_rdata;

   modport master (output xcr_a, output xcr_wdata, output xcr_we, output xcr_cs,
                   input  xcr_rdata);
   modport slave  (input  xcr_a, input  xcr_wdata, input  xcr_we, input  xcr_cs,
                   output xcr_rdata);
endinterface

// File: rtl/xcr_intc.sv
// xcr_intc: 8-source fixed-priority interrupt controller and XCR responder.
// Latches requests, arbitrates (bit 0 highest), drives INT/IVEC to the core
// and follows IN_ISP to track the start and end of service.
module xcr_intc #(
   parameter logic [7:0]  BASE      = 8'h10,
   parameter int unsigned VEC_SHIFT = 4,
   parameter logic [23:0] VBASE_RST = 24'h000100,
   parameter bit          SYNC_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  irq,
   xcr_intc_if.slave   xcr,
   input  logic        in_isp,
   output logic        int_req,
   output logic [23:0] ivec
);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cur_id_q, cur_id_d;
   logic        int_req_q, int_req_d;
   logic [7:0]  sync1_q, sync1_d;
   logic [7:0]  sync2_q, sync2_d;
   logic [7:0]  s_prev_q, s_prev_d;
   logic [7:0]  pend_q, pend_d;
   logic [7:0]  mask_q, mask_d;
   logic [7:0]  mode_q, mode_d;
   logic [23:0] vb_q, vb_d;

   logic [7:0]  s;
   logic [7:0]  off_full;
   logic [2:0]  off;
   logic        in_range;
   logic        wr;
   logic [7:0]  pend_view;
   logic [7:0]  elig;
   logic [2:0]  win;
   logic        found;
   logic [7:0]  w1c;
   logic [7:0]  swi;
   logic [7:0]  auto_clr;
   logic        busy;
   logic [2:0]  ivec_id;
   logic [23:0] id_ext;

   assign s = SYNC_EN ? sync2_q : irq;

   // Address decode, effective pending view, arbitration and read mux.
   always_comb begin
      off_full  = xcr.xcr_a - BASE;
      in_range  = (off_full[7:3] == 5'd0);
      off       = off_full[2:0];
      wr        = xcr.xcr_cs & xcr.xcr_we & in_range;
      // Level sources bypass the latch and show the conditioned input.
      pend_view = (mode_q & pend_q) | (~mode_q & s);
      elig      = pend_view & mask_q;
      win       = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (elig[i] && !found) begin
            win   = 3'(i);
            found = 1'b1;
         end
      end
      busy      = (state_q != IDLE);
      ivec_id   = (state_q == IDLE) ? 3'd0 : cur_id_q;
      id_ext    = {21'd0, ivec_id};
      ivec      = vb_q + (id_ext << VEC_SHIFT);
      xcr.xcr_rdata = '0;
      if (xcr.xcr_cs && !xcr.xcr_we && in_range) begin
         unique case (off)
            3'd0:    xcr.xcr_rdata = pend_view;
            3'd1:    xcr.xcr_rdata = mask_q;
            3'd2:    xcr.xcr_rdata = mode_q;
            3'd3:    xcr.xcr_rdata = {busy, 4'b0000, cur_id_q};
            3'd4:    xcr.xcr_rdata = vb_q[7:0];
            3'd5:    xcr.xcr_rdata = vb_q[15:8];
            3'd6:    xcr.xcr_rdata = vb_q[23:16];
            default: xcr.xcr_rdata = '0;
         endcase
      end
   end

   // Next-state: request FSM, register writes and pending-bit update.
   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      auto_clr = '0;
      unique case (state_q)
         IDLE: begin
            if (elig != 8'd0 && !in_isp) begin
               cur_id_d = win;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (in_isp) begin
               state_d = SERV;
               if (mode_q[cur_id_q]) auto_clr[cur_id_q] = 1'b1;
            end else if (!elig[cur_id_q]) begin
               state_d = IDLE;
            end
         end
         SERV: begin
            if (!in_isp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      int_req_d = (state_d == REQ);

      mask_d = mask_q;
      mode_d = mode_q;
      vb_d   = vb_q;
      w1c    = '0;
      swi    = '0;
      if (wr) begin
         unique case (off)
            3'd0:    w1c          = xcr.xcr_wdata;
            3'd1:    mask_d       = xcr.xcr_wdata;
            3'd2:    mode_d       = xcr.xcr_wdata;
            3'd4:    vb_d[7:0]    = xcr.xcr_wdata;
            3'd5:    vb_d[15:8]   = xcr.xcr_wdata;
            3'd6:    vb_d[23:16]  = xcr.xcr_wdata;
            3'd7:    swi          = xcr.xcr_wdata;
            default: ;
         endcase
      end
      // Sets are ORed in after clears so a same-edge set wins.
      pend_d   = (pend_q & ~(w1c | auto_clr)) | (s & ~s_prev_q & mode_q) | swi;
      sync1_d  = irq;
      sync2_d  = sync1_q;
      s_prev_d = s;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cur_id_q  <= '0;
         int_req_q <= 1'b0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         s_prev_q  <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         vb_q      <= VBASE_RST;
      end else begin
         state_q   <= state_d;
         cur_id_q  <= cur_id_d;
         int_req_q <= int_req_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         s_prev_q  <= s_prev_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         vb_q      <= vb_d;
      end
   end

   assign int_req = int_req_q;

endmodule

// File: tb/tb_xcr_intc.sv
// Scoreboard bench for xcr_intc: a behavioural model pushes the expected
// outputs after each edge; a negedge monitor pops and compares.
module tb_xcr_intc;
   localparam logic [7:0] BASE = 8'h10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  irq = '0;
   logic        in_isp = 1'b0;
   logic        int_req;
   logic [23:0] ivec;

   xcr_intc_if bus();

   xcr_intc #(.BASE(BASE), .VEC_SHIFT(4), .VBASE_RST(24'h000100), .SYNC_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .irq(irq), .xcr(bus), .in_isp(in_isp),
      .int_req(int_req), .ivec(ivec));

   always #5 clk = ~clk;

   typedef struct {
      bit        irq_e;
      bit [23:0] ivec_e;
      bit [7:0]  rd_e;
   } exp_t;

   exp_t sb[$];
   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   // reference model state
   bit [7:0]  m_dly[2];
   bit [7:0]  m_sprev, m_pend, m_mask, m_mode;
   bit [23:0] m_vb;
   bit        m_asking, m_serving;
   int        m_cur;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   function automatic void model_reset();
      m_dly[0] = '0; m_dly[1] = '0;
      m_sprev = '0; m_pend = '0; m_mask = '0; m_mode = '0;
      m_vb = 24'h000100; m_asking = 0; m_serving = 0; m_cur = 0;
   endfunction

   function automatic bit [7:0] view(bit [7:0] s);
      bit [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_mode[i] ? m_pend[i] : s[i];
      return v;
   endfunction

   function automatic void model_edge();
      bit [7:0] s, elig, clr, set;
      int win, off;
      if (!rst) begin model_reset(); return; end
      s    = m_dly[1];
      elig = view(s) & m_mask;
      win  = -1;
      for (int i = 0; i < 8; i++) if (elig[i] && win < 0) win = i;
      clr = '0;
      set = s & ~m_sprev & m_mode;
      if (m_asking) begin
         if (in_isp) begin
            m_asking = 0; m_serving = 1;
            if (m_mode[m_cur]) clr[m_cur] = 1'b1;
         end else if (!elig[m_cur]) m_asking = 0;
      end else if (m_serving) begin
         if (!in_isp) m_serving = 0;
      end else if (win >= 0 && !in_isp) begin
         m_cur = win; m_asking = 1;
      end
      off = int'(bus.xcr_a) - int'(BASE);
      if (bus.xcr_cs && bus.xcr_we && off >= 0 && off < 8) begin
         case (off)
            0: clr |= bus.xcr_wdata;
            1: m_mask = bus.xcr_wdata;
            2: m_mode = bus.xcr_wdata;
            4: m_vb[7:0] = bus.xcr_wdata;
            5: m_vb[15:8] = bus.xcr_wdata;
            6: m_vb[23:16] = bus.xcr_wdata;
            7: set |= bus.xcr_wdata;
            default: ;
         endcase
      end
      m_pend   = (m_pend & ~clr) | set;
      m_sprev  = s;
      m_dly[1] = m_dly[0];
      m_dly[0] = irq;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int off, id;
      id = (m_asking || m_serving) ? m_cur : 0;
      e.irq_e  = m_asking;
      e.ivec_e = 24'(m_vb + id * 16);
      e.rd_e   = '0;
      off = int'(bus.xcr_a) - int'(BASE);
      if (bus.xcr_cs && !bus.xcr_we && off >= 0 && off < 8) begin
         case (off)
            0: e.rd_e = view(m_dly[1]);
            1: e.rd_e = m_mask;
            2: e.rd_e = m_mode;
            3: e.rd_e = {m_asking || m_serving, 4'b0000, 3'(m_cur)};
            4: e.rd_e = m_vb[7:0];
            5: e.rd_e = m_vb[15:8];
            6: e.rd_e = m_vb[23:16];
            default: e.rd_e = '0;
         endcase
      end
      return e;
   endfunction

   // monitor: the DUT presents int_req/ivec/rdata every cycle
   always @(negedge clk) begin : mon
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("mon_int_req", 32'(int_req), 32'(e.irq_e));
         chk("mon_ivec", 32'(ivec), 32'(e.ivec_e));
         chk("mon_rdata", 32'(bus.xcr_rdata), 32'(e.rd_e));
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      sb.push_back(model_out());
      @(negedge clk);
      #1;
   endtask

   task automatic xwr(input int off, input logic [7:0] d);
      bus.xcr_cs = 1'b1; bus.xcr_we = 1'b1;
      bus.xcr_a = 8'(int'(BASE) + off); bus.xcr_wdata = d;
      step();
      bus.xcr_cs = 1'b0; bus.xcr_we = 1'b0;
   endtask

   task automatic xrd_chk(input int off, input logic [7:0] exp, input string nm);
      bus.xcr_cs = 1'b1; bus.xcr_we = 1'b0; bus.xcr_a = 8'(int'(BASE) + off);
      step();
      chk(nm, 32'(bus.xcr_rdata), 32'(exp));
      bus.xcr_cs = 1'b0;
   endtask

   task automatic wait_req(input int budget, input string nm);
      for (int i = 0; i < budget && !m_asking; i++) step();
      chk(nm, 32'(int_req), 32'd1);
   endtask

   initial begin
      bus.xcr_a = '0; bus.xcr_wdata = '0; bus.xcr_we = 1'b0; bus.xcr_cs = 1'b0;
      model_reset();
      #1 rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;

      // 1: reset values
      chk("t1_int_req", 32'(int_req), 32'd0);
      chk("t1_ivec", 32'(ivec), 32'h000100);
      xrd_chk(1, 8'h00, "t1_mask");
      xrd_chk(4, 8'h00, "t1_vb0");
      xrd_chk(5, 8'h01, "t1_vb1");
      xrd_chk(6, 8'h00, "t1_vb2");
      xrd_chk(3, 8'h00, "t1_cur");

      // 2: edge source accept and return
      xwr(1, 8'h04);
      xwr(2, 8'h04);
      irq = 8'h04; step(); irq = 8'h00;
      step(); step();
      chk("t2_no_req_early", 32'(int_req), 32'd0);
      step();
      chk("t2_req_3cyc", 32'(int_req), 32'd1);
      chk("t2_ivec", 32'(ivec), 32'h000120);
      in_isp = 1'b1; step();
      chk("t2_req_falls", 32'(int_req), 32'd0);
      xrd_chk(3, 8'h82, "t2_cur_busy");
      xrd_chk(0, 8'h00, "t2_pend_clr");
      in_isp = 1'b0; step();
      xrd_chk(3, 8'h02, "t2_cur_idle");

      // 3: priority via SWI
      xwr(2, 8'hFF);
      xwr(1, 8'hFF);
      xwr(7, 8'h90);
      step();
      chk("t3_req", 32'(int_req), 32'd1);
      chk("t3_ivec4", 32'(ivec), 32'h000140);
      in_isp = 1'b1; step();
      in_isp = 1'b0; step();
      step();
      chk("t3_ivec7", 32'(ivec), 32'h000170);
      in_isp = 1'b1; step();
      in_isp = 1'b0; step();

      // 4: withdrawn request
      xwr(7, 8'h08);
      step();
      chk("t4_ivec3", 32'(ivec), 32'h000130);
      xwr(1, 8'h00);
      step();
      chk("t4_withdrawn", 32'(int_req), 32'd0);
      xrd_chk(3, 8'h03, "t4_not_serv");
      xwr(0, 8'h08);

      // 5: level source
      xwr(2, 8'h00);
      xwr(1, 8'h01);
      irq = 8'h01;
      wait_req(10, "t5_req");
      in_isp = 1'b1; step();
      xwr(0, 8'h01);
      xrd_chk(0, 8'h01, "t5_level_w1c");
      in_isp = 1'b0; step();
      step();
      chk("t5_rearm", 32'(int_req), 32'd1);
      irq = 8'h00;
      in_isp = 1'b1; step();
      in_isp = 1'b0; repeat (3) step();

      // 6a: set beats W1C on the same edge
      xwr(1, 8'h00);
      xwr(2, 8'h02);
      irq = 8'h02; step(); step();
      xwr(0, 8'h02);
      xrd_chk(0, 8'h02, "t6_set_wins");
      irq = 8'h00;
      xwr(0, 8'h02);
      xrd_chk(0, 8'h00, "t6_w1c");

      // 6b: asynchronous reset while in service
      xwr(2, 8'h60);
      xwr(1, 8'h60);
      xwr(7, 8'h60);
      step();
      chk("t6_ivec5", 32'(ivec), 32'h000150);
      in_isp = 1'b1; step();
      bus.xcr_cs = 1'b1; bus.xcr_we = 1'b0; bus.xcr_a = BASE;
      #1;
      chk("t6_pend_pre", 32'(bus.xcr_rdata), 32'h40);
      rst = 1'b0;
      #1;
      chk("t6_rst_int", 32'(int_req), 32'd0);
      chk("t6_rst_pend", 32'(bus.xcr_rdata), 32'h00);
      chk("t6_rst_ivec", 32'(ivec), 32'h000100);
      model_reset();
      bus.xcr_cs = 1'b0; in_isp = 1'b0;
      @(negedge clk); #1;
      step();
      rst = 1'b1;
      step();

      // random phase
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
         if ($urandom_range(0, 3) == 0) in_isp = ~in_isp;
         bus.xcr_cs = ($urandom_range(0, 9) < 3);
         bus.xcr_we = $urandom_range(0, 1) == 1;
         bus.xcr_a = 8'(int'(BASE) - 2 + $urandom_range(0, 11));
         bus.xcr_wdata = 8'($urandom);
         step();
      end
      bus.xcr_cs = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/xcr_intc.md
Name: xcr_intc

Overview:
- XCR-bus responder and interrupt source for the KC_LS1u_plus core.
- Latches up to 8 external interrupt requests and selects one by fixed priority.
- Drives the core's INT and IVEC_addr inputs and tracks IN_ISP to know when service starts and ends.
- Mask, mode, pending and vector-base registers are accessed by the core's MOV TO/FROM XCR instructions.

Parameters:
- BASE, 8'h10: XCR address of register 0. Registers occupy BASE..BASE+7.
- VEC_SHIFT, 4: IVEC stride is 2^VEC_SHIFT words per source.
- VBASE_RST, 24'h000100: reset value of the vector base.
- SYNC_EN, 1: 1 = 2-flop synchronizer on irq; 0 = irq used directly.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- irq, in, 8: interrupt sources; bit 0 has the highest priority.
- xcr_a, in, 8: XCR address (core XCRa).
- xcr_wdata, in, 8: XCR write data (core XCRo).
- xcr_we, in, 1: XCR write strobe (core XCRwe).
- xcr_cs, in, 1: XCR select (core XCRcs).
- xcr_rdata, out, 8: read data to the core's XCRi.
- in_isp, in, 1: core IN_ISP.
- int_req, out, 1: to core INT.
- ivec, out, 24: to core IVEC_addr.

Behaviour:
- Register map (offset from BASE):
  - 0 PEND: read returns pending bits. Write-1-to-clear.
  - 1 MASK: RW, 1 = enabled. Reset 0x00.
  - 2 MODE: RW, 1 = rising-edge source, 0 = level source. Reset 0x00.
  - 3 CUR: RO, value {busy, 4'b0, cur_id[2:0]}.
  - 4/5/6 VB0/VB1/VB2: vector base bytes, low to high. Reset from VBASE_RST.
  - 7 SWI: write-1-to-set into PEND. Reads 0x00.
- Write: takes effect on the clk edge where xcr_cs & xcr_we & xcr_a in range. Repeated identical writes (core wait stalls) must be harmless; all write semantics are idempotent.
- Read: combinational. xcr_rdata = selected register when xcr_cs & !xcr_we & address in range, else 8'h00, so it can be OR-merged with other XCR responders.
- Source conditioning:
  - s = synchronized irq (2 cycles of latency when SYNC_EN = 1).
  - Edge source: PEND bit sets when s = 1 and s_prev = 0.
  - Level source: PEND bit reads s directly; W1C and auto-clear have no effect on it.
- Same-cycle conflict on one bit: set (edge or SWI) beats W1C/auto-clear.
- Eligibility: elig = PEND & MASK. Winner = lowest set index.
- FSM states IDLE, REQ, SERV. Reset state is IDLE.
  - IDLE: when elig != 0 and in_isp = 0, latch cur_id = winner and go to REQ.
  - REQ:
    - int_req = 1 and ivec = VB + (cur_id << VEC_SHIFT), 24-bit sum, carry discarded.
    - If in_isp = 1: go to SERV. If the cur_id source is edge-mode, auto-clear its PEND bit on that edge.
    - Else if elig[cur_id] = 0 (masked, or cleared by software): go to IDLE with no acceptance.
    - cur_id and ivec stay stable throughout REQ.
  - SERV: int_req = 0, busy = 1. When in_isp = 0 (core RET), go to IDLE. Re-arbitration can assert int_req the cycle after.
- int_req is registered: high exactly in REQ. busy is high in REQ and SERV.
- If in_isp is already high while in IDLE, no request is raised until it falls.
- VB writes during REQ update ivec immediately; software must not do this.
- Reset asserted mid-operation: all state returns to reset values immediately. int_req = 0, ivec = VBASE_RST, PEND = 0, sync flops = 0, xcr_rdata = 0 when not selected.
- ivec in IDLE = VB + (0 << VEC_SHIFT).

Test Plan:
1. Reset then read: MASK = 0x00, VB = 0x00,0x01,0x00, int_req = 0, CUR = 0x00.
2. Edge accept and return: MASK = 0x04, MODE = 0x04, pulse irq[2].
   - int_req rises 3 cycles after the pulse (SYNC_EN = 1); ivec = 0x000120.
   - Raise in_isp: int_req falls next cycle, PEND[2] = 0, CUR = 0x82.
   - Drop in_isp: CUR = 0x02 and the FSM is back in IDLE.
3. Priority: MASK = 0xFF, SWI write 0x90 → cur_id = 4 and ivec = 0x000140. After service completes, the next request has ivec = 0x000170.
4. Withdrawn request: in REQ for source 3, write MASK = 0x00 → int_req drops next cycle and no SERV is entered.
5. Level source: MODE = 0x00, MASK = 0x01, hold irq[0] high through service → after in_isp falls, int_req re-asserts. Writing PEND 0x01 does not clear it.
6. Conflicts and reset:
   - W1C PEND 0x02 on the same edge as an irq[1] rising edge → PEND[1] stays 1.
   - Assert rst in SERV → int_req = 0 and PEND = 0 asynchronously.
